// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS BERT controller and its datapath neighbours.
package prbs_pkg;

  // Bits per cycle on the generator/monitor datapath this controller sequences
  localparam int OUTLENGTH = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESYNC  = 3'd1,
    ACQUIRE = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_TIMEOUT = 2'd1,
    STAT_ABORTED = 2'd2,
    STAT_RSVD    = 2'd3
  } status_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prbs_bert_controller_if.sv
// Control/status bundle between the test layer, PRBS monitor and the BERT controller.
interface prbs_bert_controller_if #(
  parameter int ERRW = 16
);
  logic            start;
  logic            abort;
  logic            lock;
  logic            bit_error;
  logic            mon_rst_n;
  logic            gen_en;
  logic            busy;
  logic            done;
  logic            pass;
  logic [1:0]      status;
  logic [ERRW-1:0] err_count;
  logic [ERRW-1:0] loss_count;

  // master: test layer + monitor side; slave: the controller
  modport master (
    output start, abort, lock, bit_error,
    input  mon_rst_n, gen_en, busy, done, pass, status, err_count, loss_count
  );

  modport slave (
    input  start, abort, lock, bit_error,
    output mon_rst_n, gen_en, busy, done, pass, status, err_count, loss_count
  );
endinterface

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes next value for same-cycle decisions.
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (en_i && (cnt_q != '1))  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
endmodule

// File: rtl/prbs_bert_controller.sv
// BERT sequencer: resync monitor, wait for sustained lock, count errors over a window, report.
module prbs_bert_controller
  import prbs_pkg::*;
#(
  parameter int RST_CYCLES   = 4,
  parameter int LOCK_CONSEC  = 8,
  parameter int LOCK_TIMEOUT = 256,
  parameter int WINDOW       = 1024,
  parameter int ERRW         = 16,
  parameter int ERR_THRESH   = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  prbs_bert_controller_if.slave bus
);
  localparam int TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, WINDOW);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int LW   = $clog2(LOCK_CONSEC + 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            gen_en_q, gen_en_d;
  logic            mon_rst_n_q, mon_rst_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [1:0]      status_q, status_d;

  logic            running, go, abort_hit, lock_hit, tmo, meas_end, meas_cnt;
  logic [ERRW-1:0] err_cnt, err_nxt, loss_cnt, loss_nxt;

  assign running   = (state_q == RESYNC) || (state_q == ACQUIRE) || (state_q == MEASURE);
  // abort beats start; start only takes effect while idle or finished
  assign go        = bus.start && !bus.abort && !running;
  assign abort_hit = bus.abort && running;
  assign lock_hit  = (state_q == ACQUIRE) && bus.lock && (lock_cnt_q == LW'(LOCK_CONSEC - 1));
  assign tmo       = (state_q == ACQUIRE) && !bus.abort && !lock_hit && (timer_q == '0);
  assign meas_end  = (state_q == MEASURE) && !bus.abort && (timer_q == '0);
  assign meas_cnt  = (state_q == MEASURE) && !bus.abort;

  // ---- state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (go) state_d = RESYNC;
      RESYNC: begin
        if (bus.abort)           state_d = DONE;
        else if (timer_q == '0)  state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (bus.abort)           state_d = DONE;
        else if (lock_hit)       state_d = MEASURE;
        else if (timer_q == '0)  state_d = DONE;
      end
      MEASURE: begin
        if (bus.abort)           state_d = DONE;
        else if (timer_q == '0)  state_d = DONE;
      end
      default:                   state_d = IDLE;
    endcase
  end

  // ---- outputs and datapath next values
  always_comb begin
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    // single phase timer, reloaded whenever a new state is entered
    if (state_d != state_q) begin
      case (state_d)
        RESYNC:  timer_d = TW'(RST_CYCLES - 1);
        ACQUIRE: timer_d = TW'(LOCK_TIMEOUT - 1);
        MEASURE: timer_d = TW'(WINDOW - 1);
        default: timer_d = '0;
      endcase
    end

    lock_cnt_d = '0;
    if (state_q == ACQUIRE && bus.lock) lock_cnt_d = lock_cnt_q + LW'(1);

    status_d = status_q;
    pass_d   = pass_q;
    if (go) begin
      status_d = STAT_OK;
      pass_d   = 1'b0;
    end else if (abort_hit) begin
      status_d = STAT_ABORTED;
      pass_d   = 1'b0;
    end else if (tmo) begin
      status_d = STAT_TIMEOUT;
      pass_d   = 1'b0;
    end else if (meas_end) begin
      status_d = STAT_OK;
      pass_d   = (err_nxt <= ERRW'(ERR_THRESH)) && (loss_nxt == '0);
    end

    gen_en_d    = (state_d == RESYNC) || (state_d == ACQUIRE) || (state_d == MEASURE);
    busy_d      = gen_en_d;
    mon_rst_n_d = (state_d == ACQUIRE) || (state_d == MEASURE) || (state_d == DONE);
    done_d      = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q     <= '0;
      lock_cnt_q  <= '0;
      gen_en_q    <= 1'b0;
      mon_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      status_q    <= STAT_OK;
    end else begin
      timer_q     <= timer_d;
      lock_cnt_q  <= lock_cnt_d;
      gen_en_q    <= gen_en_d;
      mon_rst_n_q <= mon_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      status_q    <= status_d;
    end
  end

  prbs_sat_counter #(.W(ERRW)) u_err_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (go),
    .en_i      (meas_cnt && bus.bit_error),
    .cnt_o     (err_cnt),
    .cnt_nxt_o (err_nxt)
  );

  prbs_sat_counter #(.W(ERRW)) u_loss_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (go),
    .en_i      (meas_cnt && !bus.lock),
    .cnt_o     (loss_cnt),
    .cnt_nxt_o (loss_nxt)
  );

  assign bus.gen_en     = gen_en_q;
  assign bus.mon_rst_n  = mon_rst_n_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.status     = status_q;
  assign bus.err_count  = err_cnt;
  assign bus.loss_count = loss_cnt;
endmodule

// File: tb/tb_prbs_bert_controller.sv
// Directed/randomized bench for prbs_bert_controller against a per-cycle outcome model.
module tb_prbs_bert_controller;
  localparam int RST = 4, LC = 8, LT = 256, W = 1024, W4 = 64;
  localparam int ACQ0 = 1 + RST;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs_bert_controller_if #(.ERRW(16)) bus  ();
  prbs_bert_controller_if #(.ERRW(4))  bus4 ();

  prbs_bert_controller #(
    .RST_CYCLES(RST), .LOCK_CONSEC(LC), .LOCK_TIMEOUT(LT),
    .WINDOW(W), .ERRW(16), .ERR_THRESH(0)
  ) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  prbs_bert_controller #(
    .RST_CYCLES(RST), .LOCK_CONSEC(LC), .LOCK_TIMEOUT(LT),
    .WINDOW(W4), .ERRW(4), .ERR_THRESH(0)
  ) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4.slave));

  int   n_chk = 0, n_err = 0;
  logic lock_v [0:2047];
  logic err_v  [0:2047];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic a, input logic l, input logic e);
    if (sel == 0) begin bus.start = s;  bus.abort = a;  bus.lock = l;  bus.bit_error = e;  end
    else          begin bus4.start = s; bus4.abort = a; bus4.lock = l; bus4.bit_error = e; end
  endtask

  task automatic sample(input int sel, output logic d, output logic g, output logic b,
                        output logic m, output logic p, output logic [1:0] st,
                        output logic [15:0] ec, output logic [15:0] lc);
    if (sel == 0) begin
      d = bus.done; g = bus.gen_en; b = bus.busy; m = bus.mon_rst_n; p = bus.pass;
      st = bus.status; ec = bus.err_count; lc = bus.loss_count;
    end else begin
      d = bus4.done; g = bus4.gen_en; b = bus4.busy; m = bus4.mon_rst_n; p = bus4.pass;
      st = bus4.status; ec = {12'd0, bus4.err_count}; lc = {12'd0, bus4.loss_count};
    end
  endtask

  // Outcome of a test whose start pulse is cycle 0, from the per-cycle lock/error arrays
  task automatic model(input int win, input int emax, input int abort_at,
                       output int e_done, output int e_stat, output int e_pass,
                       output int e_err, output int e_loss);
    int run, ms;
    run = 0; ms = -1; e_err = 0; e_loss = 0; e_pass = 0;
    if (abort_at >= 1 && abort_at < ACQ0) begin
      e_done = abort_at + 1; e_stat = 2; return;
    end
    for (int t = ACQ0; t < ACQ0 + LT; t++) begin
      if (t == abort_at) begin e_done = t + 1; e_stat = 2; return; end
      run = lock_v[t] ? run + 1 : 0;
      if (run >= LC) begin ms = t + 1; break; end
    end
    if (ms < 0) begin e_done = ACQ0 + LT; e_stat = 1; return; end
    for (int t = ms; t < ms + win; t++) begin
      if (t == abort_at) begin e_done = t + 1; e_stat = 2; return; end
      if (err_v[t]  && e_err  < emax) e_err++;
      if (!lock_v[t] && e_loss < emax) e_loss++;
    end
    e_done = ms + win; e_stat = 0;
    e_pass = (e_err == 0 && e_loss == 0) ? 1 : 0;
  endtask

  task automatic fill(input int lock_from);
    for (int i = 0; i < 2048; i++) begin
      lock_v[i] = (i >= lock_from);
      err_v[i]  = 1'b0;
    end
  endtask

  task automatic run(input string tag, input int sel, input int abort_at);
    int e_done, e_stat, e_pass, e_err, e_loss, done_at, win, emax;
    logic d, g, b, m, p;
    logic [1:0] st;
    logic [15:0] ec, lc;
    win  = (sel == 0) ? W : W4;
    emax = (sel == 0) ? 65535 : 15;
    model(win, emax, abort_at, e_done, e_stat, e_pass, e_err, e_loss);
    done_at = -1;
    for (int c = 0; c < e_done + 20 && done_at < 0; c++) begin
      @(negedge clk);
      drive(sel, (c == 0) || (c == abort_at), c == abort_at, lock_v[c], err_v[c]);
      @(posedge clk); #1;
      sample(sel, d, g, b, m, p, st, ec, lc);
      if (c == 0) begin
        chk({tag, ".gen_en_lat"}, {31'd0, g}, 32'd1);
        chk({tag, ".busy_lat"},   {31'd0, b}, 32'd1);
        chk({tag, ".mrn_resync"}, {31'd0, m}, 32'd0);
      end
      if (d) done_at = c + 1;
    end
    chk({tag, ".done_at"}, done_at, e_done);
    chk({tag, ".status"},  {30'd0, st}, e_stat);
    chk({tag, ".pass"},    {31'd0, p}, e_pass);
    chk({tag, ".err"},     {16'd0, ec}, e_err);
    chk({tag, ".loss"},    {16'd0, lc}, e_loss);
    chk({tag, ".gen_en"},  {31'd0, g}, 32'd0);
    chk({tag, ".busy"},    {31'd0, b}, 32'd0);
    chk({tag, ".mrn"},     {31'd0, m}, 32'd1);
    // noisy inputs while in DONE must leave results untouched
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    sample(sel, d, g, b, m, p, st, ec, lc);
    chk({tag, ".done_pulse"}, {31'd0, d}, 32'd0);
    chk({tag, ".err_hold"},   {16'd0, ec}, e_err);
    chk({tag, ".loss_hold"},  {16'd0, lc}, e_loss);
    chk({tag, ".stat_hold"},  {30'd0, st}, e_stat);
  endtask

  task automatic chk_reset(input string tag, input int sel);
    logic d, g, b, m, p;
    logic [1:0] st;
    logic [15:0] ec, lc;
    sample(sel, d, g, b, m, p, st, ec, lc);
    chk({tag, ".done"},   {31'd0, d}, 32'd0);
    chk({tag, ".gen_en"}, {31'd0, g}, 32'd0);
    chk({tag, ".busy"},   {31'd0, b}, 32'd0);
    chk({tag, ".mrn"},    {31'd0, m}, 32'd0);
    chk({tag, ".pass"},   {31'd0, p}, 32'd0);
    chk({tag, ".status"}, {30'd0, st}, 32'd0);
    chk({tag, ".err"},    {16'd0, ec}, 32'd0);
    chk({tag, ".loss"},   {16'd0, lc}, 32'd0);
  endtask

  initial begin
    int d;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst", 0);
    chk_reset("rst4", 1);
    @(negedge clk) rst = 1'b0;

    // clean link, lock as soon as the monitor leaves reset
    fill(ACQ0);
    run("clean", 0, -1);

    // one flipped bit somewhere in the window
    fill(ACQ0);
    err_v[ACQ0 + LC + $urandom_range(0, W - 1)] = 1'b1;
    run("flip", 0, -1);

    // random acquisition jitter plus sparse errors and lock drops
    for (int k = 0; k < 3; k++) begin
      d = $urandom_range(0, 40);
      for (int i = 0; i < 2048; i++) begin
        lock_v[i] = (i < ACQ0 + d) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) != 0);
        err_v[i]  = ($urandom_range(0, 31) == 0);
      end
      run("rand", 0, -1);
    end

    // lock never asserted
    fill(2048);
    run("tmo_nolock", 0, -1);

    // runs of 7 never reach LOCK_CONSEC; runs of 8 just do
    for (int i = 0; i < 2048; i++) begin lock_v[i] = (i % 8) != 7; err_v[i] = 1'b0; end
    run("tmo_run7", 0, -1);
    for (int i = 0; i < 2048; i++) begin lock_v[i] = (i % 9) != 8; err_v[i] = 1'b0; end
    run("acq_run8", 0, -1);

    // lock completes on the last ACQUIRE cycle: lock beats timeout
    fill(2048);
    for (int t = ACQ0 + LT - LC; t < ACQ0 + LT; t++) lock_v[t] = 1'b1;
    for (int t = ACQ0 + LT; t < 2048; t++) lock_v[t] = 1'b1;
    run("lock_wins", 0, -1);

    // abort 10 cycles into MEASURE together with start
    fill(ACQ0);
    err_v[ACQ0 + LC + 2] = 1'b1;
    err_v[ACQ0 + LC + 5] = 1'b1;
    lock_v[ACQ0 + LC + 7] = 1'b0;
    for (int t = ACQ0 + LC + 11; t < 2048; t++) begin err_v[t] = 1'b1; lock_v[t] = 1'b0; end
    run("abort_meas", 0, ACQ0 + LC + 10);

    fill(2048);
    run("abort_resync", 0, 2);
    run("abort_acq", 0, 50);

    // reset while in ACQUIRE, then a fresh clean test
    @(negedge clk); drive(0, 1, 0, 0, 0);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      @(negedge clk); drive(0, 0, 0, 0, 0);
    end
    #1;
    chk("acq.busy", {31'd0, bus.busy}, 32'd1);
    chk("acq.mrn",  {31'd0, bus.mon_rst_n}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("rst_acq", 0);
    @(negedge clk) rst = 1'b0;
    fill(ACQ0);
    run("post_rst", 0, -1);

    // narrow counters saturate instead of wrapping
    fill(ACQ0);
    for (int i = 0; i < 2048; i++) err_v[i] = 1'b1;
    run("sat_err", 1, -1);
    for (int i = 0; i < 2048; i++) lock_v[i] = (i >= ACQ0 && i < ACQ0 + LC);
    run("sat_loss", 1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
